// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snn_pkg
// Description : Shared state encoding, default widths and clamp helper for
//               the multistep spiking classifier.
// Revision    : 1.0 - initial release
// ============================================================================
package snn_pkg;

    localparam int c_DEF_M1      = 8;
    localparam int c_DEF_N1      = 8;
    localparam int c_DEF_N2      = 8;
    localparam int c_DEF_WGT_W   = 2;
    localparam int c_DEF_MEM_W   = 6;
    localparam int c_DEF_DECAY_W = 3;
    localparam int c_DEF_REF_W   = 5;
    localparam int c_DEF_STEP_W  = 8;
    localparam int c_DEF_CNT_W   = 8;

    localparam int c_STATE_W = 3;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_CLEAR = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_RUN   = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_DRAIN = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_DONE  = 3'd4;

    // Used both for membrane clamping and for saturating counters.
    function automatic int clamp_int(input int val, input int lo, input int hi);
        if (val < lo) return lo;
        if (val > hi) return hi;
        return val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snn_lif_layer.sv
`default_nettype none
// ============================================================================
// Module      : snn_lif_layer
// Description : One fully connected layer of leaky integrate-and-fire neurons
//               with refractory period, updated on an external strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module snn_lif_layer
    import snn_pkg::*;
#(
    parameter int M       = c_DEF_M1,
    parameter int N       = c_DEF_N1,
    parameter int WGT_W   = c_DEF_WGT_W,
    parameter int MEM_W   = c_DEF_MEM_W,
    parameter int DECAY_W = c_DEF_DECAY_W,
    parameter int REF_W   = c_DEF_REF_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   update,
    input  logic                   clear,
    input  logic [M-1:0]           in_spikes,
    input  logic [N*M*WGT_W-1:0]   weights,
    input  logic [MEM_W-1:0]       threshold,
    input  logic [DECAY_W-1:0]     decay,
    input  logic [REF_W-1:0]       refractory,
    output logic [N-1:0]           spikes,
    output logic [N-1:0]           fire,
    output logic [N*MEM_W-1:0]     membranes
);

    localparam int c_MEM_MAX = (1 << MEM_W) - 1;

    for (genvar n = 0; n < N; n++) begin : g_neuron
        logic [MEM_W-1:0] r_mem;
        logic [REF_W-1:0] r_ref;
        logic             r_spike;
        int               w_sum;
        int               w_vnext;
        logic             w_fire;

        // Integer arithmetic so negative sums are visible before clamping.
        always_comb begin
            w_sum = int'(r_mem) - int'(decay);
            if (w_sum < 0) w_sum = 0;
            for (int m = 0; m < M; m++) begin
                if (in_spikes[m])
                    w_sum = w_sum + int'($signed(weights[(n*M+m)*WGT_W +: WGT_W]));
            end
            w_vnext = clamp_int(w_sum, 0, c_MEM_MAX);
            w_fire  = (r_ref == '0) && (w_vnext >= int'(threshold));
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_mem   <= '0;
                r_ref   <= '0;
                r_spike <= 1'b0;
            end else if (clear) begin
                r_mem   <= '0;
                r_ref   <= '0;
                r_spike <= 1'b0;
            end else if (update) begin
                if (r_ref != '0) begin
                    r_ref   <= r_ref - 1'b1;
                    r_mem   <= '0;
                    r_spike <= 1'b0;
                end else if (w_fire) begin
                    r_mem   <= '0;
                    r_ref   <= refractory;
                    r_spike <= 1'b1;
                end else begin
                    r_mem   <= MEM_W'(w_vnext);
                    r_spike <= 1'b0;
                end
            end
        end

        assign spikes[n]                   = r_spike;
        assign fire[n]                     = update & w_fire;
        assign membranes[n*MEM_W +: MEM_W] = r_mem;
    end

endmodule
`default_nettype wire

// File: rtl/snn_multistep_classifier.sv
`default_nettype none
// ============================================================================
// Module      : snn_multistep_classifier
// Description : Two-layer LIF classifier with timestep sequencer, per-class
//               spike counting and argmax readout. Optional membrane debug
//               port enabled by SNN_MEMBRANE_DEBUG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module snn_multistep_classifier
    import snn_pkg::*;
#(
    parameter int M1      = c_DEF_M1,
    parameter int N1      = c_DEF_N1,
    parameter int N2      = c_DEF_N2,
    parameter int WGT_W   = c_DEF_WGT_W,
    parameter int MEM_W   = c_DEF_MEM_W,
    parameter int DECAY_W = c_DEF_DECAY_W,
    parameter int REF_W   = c_DEF_REF_W,
    parameter int STEP_W  = c_DEF_STEP_W,
    parameter int CNT_W   = c_DEF_CNT_W,
    localparam int c_WIN_W = (N2 > 1) ? $clog2(N2) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [STEP_W-1:0]         num_steps,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [M1-1:0]             input_spikes,
    input  logic [N1*M1*WGT_W-1:0]    weights1,
    input  logic [N2*N1*WGT_W-1:0]    weights2,
    input  logic [MEM_W-1:0]          threshold1,
    input  logic [MEM_W-1:0]          threshold2,
    input  logic [DECAY_W-1:0]        decay1,
    input  logic [DECAY_W-1:0]        decay2,
    input  logic [REF_W-1:0]          refractory1,
    input  logic [REF_W-1:0]          refractory2,
    output logic [N1-1:0]             spikes_l1,
    output logic [N2-1:0]             spikes_l2,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N2*CNT_W-1:0]       spike_counts,
    output logic [c_WIN_W-1:0]        winner
`ifdef SNN_MEMBRANE_DEBUG_EN
    ,
    output logic [(N1+N2)*MEM_W-1:0]  membrane_potential_out
`endif
);

    localparam int c_CNT_MAX = (1 << CNT_W) - 1;

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_next;
    logic [STEP_W-1:0]    r_num_steps;
    logic [STEP_W-1:0]    r_step_cnt;
    logic                 r_l2_update;
    logic [CNT_W-1:0]     r_counts [N2];
    logic [CNT_W-1:0]     w_cnt_next [N2];
    logic                 w_accept;
    logic                 w_last;
    logic                 w_clear;
    logic [N2-1:0]        w_l2_fire;
    logic [N1-1:0]        w_unused_l1_fire;
    logic [N1*MEM_W-1:0]  w_mem_l1;
    logic [N2*MEM_W-1:0]  w_mem_l2;
    logic [CNT_W-1:0]     w_best_cnt;
    logic [c_WIN_W-1:0]   w_winner;

    assign w_accept = (r_state == c_ST_RUN) && in_valid;
    assign w_last   = (r_step_cnt == r_num_steps - 1'b1);
    // Counters are also cleared on start so a zero-step run reports zeros.
    assign w_clear  = ((r_state == c_ST_IDLE) && start) || (r_state == c_ST_CLEAR);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (start) w_state_next = (num_steps == '0) ? c_ST_DONE : c_ST_CLEAR;
            c_ST_CLEAR: w_state_next = c_ST_RUN;
            c_ST_RUN:   if (in_valid && w_last) w_state_next = c_ST_DRAIN;
            c_ST_DRAIN: w_state_next = c_ST_DONE;
            c_ST_DONE:  if (out_ready) w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        for (int n = 0; n < N2; n++)
            w_cnt_next[n] = CNT_W'(clamp_int(int'(r_counts[n]) + 1, 0, c_CNT_MAX));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_num_steps <= '0;
            r_step_cnt  <= '0;
            r_l2_update <= 1'b0;
            for (int n = 0; n < N2; n++) r_counts[n] <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == c_ST_IDLE) && start) r_num_steps <= num_steps;
            if (w_clear) begin
                r_step_cnt  <= '0;
                r_l2_update <= 1'b0;
                for (int n = 0; n < N2; n++) r_counts[n] <= '0;
            end else begin
                // Layer 2 trails layer 1 by exactly one edge.
                r_l2_update <= w_accept;
                if (w_accept && !w_last) r_step_cnt <= r_step_cnt + 1'b1;
                if (r_l2_update) begin
                    for (int n = 0; n < N2; n++)
                        if (w_l2_fire[n]) r_counts[n] <= w_cnt_next[n];
                end
            end
        end
    end

    snn_lif_layer #(
        .M(M1), .N(N1), .WGT_W(WGT_W), .MEM_W(MEM_W), .DECAY_W(DECAY_W), .REF_W(REF_W)
    ) u_layer1 (
        .clk        (clk),
        .reset      (reset),
        .update     (w_accept),
        .clear      (w_clear),
        .in_spikes  (input_spikes),
        .weights    (weights1),
        .threshold  (threshold1),
        .decay      (decay1),
        .refractory (refractory1),
        .spikes     (spikes_l1),
        .fire       (w_unused_l1_fire),
        .membranes  (w_mem_l1)
    );

    snn_lif_layer #(
        .M(N1), .N(N2), .WGT_W(WGT_W), .MEM_W(MEM_W), .DECAY_W(DECAY_W), .REF_W(REF_W)
    ) u_layer2 (
        .clk        (clk),
        .reset      (reset),
        .update     (r_l2_update),
        .clear      (w_clear),
        .in_spikes  (spikes_l1),
        .weights    (weights2),
        .threshold  (threshold2),
        .decay      (decay2),
        .refractory (refractory2),
        .spikes     (spikes_l2),
        .fire       (w_l2_fire),
        .membranes  (w_mem_l2)
    );

    // Lowest index wins ties because only a strictly larger count replaces it.
    always_comb begin
        w_best_cnt = r_counts[0];
        w_winner   = '0;
        for (int n = 1; n < N2; n++) begin
            if (r_counts[n] > w_best_cnt) begin
                w_best_cnt = r_counts[n];
                w_winner   = c_WIN_W'(n);
            end
        end
    end

    for (genvar n = 0; n < N2; n++) begin : g_counts
        assign spike_counts[n*CNT_W +: CNT_W] = r_counts[n];
    end

    assign winner    = w_winner;
    assign in_ready  = (r_state == c_ST_RUN);
    assign busy      = (r_state != c_ST_IDLE);
    assign out_valid = (r_state == c_ST_DONE);

`ifdef SNN_MEMBRANE_DEBUG_EN
    assign membrane_potential_out = {w_mem_l2, w_mem_l1};
`else
    logic w_unused_mem;
    assign w_unused_mem = ^{w_mem_l2, w_mem_l1};
`endif

endmodule
`default_nettype wire

// File: doc/snn_multistep_classifier.md
Name: snn_multistep_classifier

Overview:
- Parametrised two-layer leaky integrate-and-fire (LIF) spiking network, wrapped in an inference sequencer.
- Runs a programmable number of timesteps per inference: accepts one input spike vector per timestep via valid/ready, pipelines layer 2 one cycle behind layer 1, counts output spikes per class, and reports counts plus the winning class via an out_valid/out_ready handshake.
- Sits between the spike-encoder front end and the host readout registers.

Parameters:
- M1, 8, input spike lines
- N1, 8, layer-1 neurons
- N2, 8, layer-2 neurons (classes)
- WGT_W, 2, signed two's-complement weight width
- MEM_W, 6, unsigned membrane potential width
- DECAY_W, 3, decay width
- REF_W, 5, refractory counter width
- STEP_W, 8, timestep counter width
- CNT_W, 8, per-class spike counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin inference; sampled only in IDLE
- num_steps  in  STEP_W  timesteps per inference; latched on start
- in_valid  in  1  input timestep valid
- in_ready  out  1  block accepts a timestep
- input_spikes  in  M1  spikes for the current timestep
- weights1  in  N1*M1*WGT_W  weight index (n*M1+m)*WGT_W
- weights2  in  N2*N1*WGT_W  same layout
- threshold1, threshold2  in  MEM_W  firing thresholds
- decay1, decay2  in  DECAY_W  per-step leak
- refractory1, refractory2  in  REF_W  refractory periods
- spikes_l1  out  N1  registered layer-1 spikes, latest step
- spikes_l2  out  N2  registered layer-2 spikes, latest step
- busy  out  1  high in every state except IDLE
- out_valid  out  1  result available
- out_ready  in  1  host consumes result
- spike_counts  out  N2*CNT_W  per-class counts
- winner  out  max(1,$clog2(N2))  argmax class

Behaviour:
- Reset values: all outputs 0; state IDLE; membranes, refractory counters, spike counts and step counter 0.
- States:
  - IDLE: start=1 latches num_steps and goes to CLEAR; if num_steps==0, goes directly to DONE with counts 0 and winner 0.
  - CLEAR (1 cycle): zero membranes, refractory counters, spike counts, step counter and spike registers, then go to RUN.
  - RUN: in_ready=1. A timestep is accepted on an edge where in_valid&in_ready. Accepting the step where step_cnt==num_steps-1 goes to DRAIN; otherwise step_cnt increments.
  - DRAIN (1 cycle): in_ready=0; layer 2 processes the final step, then go to DONE.
  - DONE: out_valid=1; counts and winner held stable; out_ready=1 returns to IDLE.
- start outside IDLE is ignored.
- Layer 1 updates on the accept edge. Layer 2 updates on the following edge using spikes_l1, i.e. a one-cycle pipeline; layer-2 updates for step k and layer-1 updates for step k+1 may share an edge.
- LIF update per neuron on its update edge:
  - If ref>0: ref decrements, V=0, no spike.
  - Otherwise: V' = max(V-decay,0) + sum of signed weights on active inputs. Compute in a width wide enough for the full sum, then clamp to [0, 2^MEM_W-1].
  - If V'>=threshold: spike=1, V=0, ref=refractory. Otherwise V=V', spike=0.
  - threshold=0 means the neuron fires on every non-refractory update.
- Each layer-2 spike increments its class counter, saturating at 2^CNT_W-1.
- winner is combinational from the count registers: lowest index with the maximum count; 0 when all counts are 0.
- Latency: start sampled at edge 0 → in_ready high after edge 1; final accept at edge e → out_valid high after edge e+1.
- Reset asserted mid-inference aborts it immediately; all state returns to reset values.

Optional Feature:
- Macro SNN_MEMBRANE_DEBUG_EN.
  - Defined: adds output membrane_potential_out, (N1+N2)*MEM_W, carrying live membranes (layer 1 in the low bits, neuron 0 lowest).
  - Undefined: the port does not exist; behaviour is otherwise identical.

Decomposition:
- Shared package snn_pkg: state encoding (IDLE, CLEAR, RUN, DRAIN, DONE), clamp/saturation helper function, default width constants.
- One natural sub-module: snn_lif_layer (parametrised M, N, widths; update strobe, clear, weights, threshold, decay, refractory → spikes, membranes). Instantiated twice.

Test Plan:
- Single weight1[0][0]=+1, others 0, threshold1=2, decay=0, refractory=0, w2[0][0]=+1, threshold2=1; num_steps=4, input_spikes=1 every step → layer-1 neuron 0 fires on steps 2 and 4; spike_counts[0]=2; winner=0.
- Timing: num_steps=3, start sampled at edge 0, in_valid held high → accepts at edges 2,3,4; out_valid rises after edge 5; in_valid with out_ready low holds DONE with no acceptance.
- Refractory=2, threshold 1, constant drive → spike every third step; negative weights drive V' below 0 → V clamps to 0, never wraps.
- Saturation: CNT_W=2, layer-2 neuron firing each step for 6 steps → count 3. Tie at class 1 and class 3 → winner=1.
- num_steps=0 → DONE one edge after start, counts 0. Reset asserted during RUN → busy=0, in_ready=0, counts 0 next cycle.
- in_valid bubbles, random on/off → results identical to the back-to-back run.
